// File: rtl/axis_adder_pkg.sv
// Shared definitions for the AXI-Stream adder: skid buffer state encoding
// and operand extension mode constants.
package axis_adder_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    localparam int MODE_UNSIGNED = 0;
    localparam int MODE_SIGNED   = 1;

endpackage : axis_adder_pkg

// File: rtl/axis_skid_buffer.sv
// Two-entry registered output buffer: 1-cycle latency, full throughput, and
// a "space" flag derived from registered state only.
module axis_skid_buffer
    import axis_adder_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              space_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i
);

    buf_state_e        state_reg, state_next;
    logic [DATA_W-1:0] head_reg, head_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              accept;

    assign accept    = rd_valid_o & rd_ready_i;
    assign rd_data_o = head_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

    // Head always holds the oldest beat; skid only fills when head is stalled.
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (wr_valid_i) begin
                    head_next  = wr_data_i;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (wr_valid_i && accept) begin
                    head_next = wr_data_i;
                end else if (wr_valid_i) begin
                    skid_next  = wr_data_i;
                    state_next = ST_FULL;
                end else if (accept) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    head_next  = skid_reg;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        space_o    = (state_reg != ST_FULL);
        rd_valid_o = (state_reg != ST_EMPTY);
    end

endmodule : axis_skid_buffer

// File: rtl/axis_adder.sv
// Joins one beat from each of two AXI-Stream inputs and emits their
// (WIDTH+1)-bit sum through a 2-entry output buffer.
module axis_adder
    import axis_adder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SIGNED_MODE = MODE_UNSIGNED
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] s_axis1_tdata_i,
    input  logic             s_axis1_tvalid_i,
    input  logic             s_axis1_tlast_i,
    output logic             s_axis1_tready_o,
    input  logic [WIDTH-1:0] s_axis2_tdata_i,
    input  logic             s_axis2_tvalid_i,
    input  logic             s_axis2_tlast_i,
    output logic             s_axis2_tready_o,
    output logic [WIDTH:0]   m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    output logic             m_axis_tlast_o,
    input  logic             m_axis_tready_i,
    output logic             tlast_err_o
);

    localparam int SUM_W = WIDTH + 1;
    localparam int BUF_W = WIDTH + 2;

    logic             space;
    logic             space_ok;
    logic             fire;
    logic [WIDTH-1:0] op     [2];
    logic [SUM_W-1:0] op_ext [2];
    logic [SUM_W-1:0] sum;
    logic [BUF_W-1:0] buf_wr_data;
    logic [BUF_W-1:0] buf_rd_data;
    logic             tlast_err_reg;

    assign op[0] = s_axis1_tdata_i;
    assign op[1] = s_axis2_tdata_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ext
            logic ext_bit;
            assign ext_bit     = (SIGNED_MODE == MODE_SIGNED) ? op[gi][WIDTH-1] : 1'b0;
            assign op_ext[gi]  = {ext_bit, op[gi]};
        end
    endgenerate

    // One extra bit of headroom means the sum can never overflow.
    assign sum = op_ext[0] + op_ext[1];

    // Nothing is consumed while reset is held, even though the buffer reads empty.
    assign space_ok         = space & ~rst_i;
    assign s_axis1_tready_o = s_axis2_tvalid_i & space_ok;
    assign s_axis2_tready_o = s_axis1_tvalid_i & space_ok;
    assign fire             = s_axis1_tvalid_i & s_axis2_tvalid_i & space_ok;

    assign buf_wr_data = {s_axis1_tlast_i, sum};

    axis_skid_buffer #(
        .DATA_W (BUF_W)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_valid_i (fire),
        .wr_data_i  (buf_wr_data),
        .space_o    (space),
        .rd_valid_o (m_axis_tvalid_o),
        .rd_data_o  (buf_rd_data),
        .rd_ready_i (m_axis_tready_i)
    );

    assign m_axis_tdata_o = buf_rd_data[SUM_W-1:0];
    assign m_axis_tlast_o = buf_rd_data[BUF_W-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tlast_err_reg <= 1'b0;
        end else if (fire && (s_axis1_tlast_i != s_axis2_tlast_i)) begin
            tlast_err_reg <= 1'b1;
        end
    end

    assign tlast_err_o = tlast_err_reg;

endmodule : axis_adder

// File: tb/tb_axis_adder.sv
// Bench for axis_adder: one unsigned and one signed WIDTH=4 instance, table
// vectors plus skew / backpressure / tlast / reset sequences and a scoreboard.
module tb_axis_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Unsigned instance signals
    logic [3:0] u_d1 = '0, u_d2 = '0;
    logic       u_v1 = 0, u_v2 = 0, u_l1 = 0, u_l2 = 0, u_mr = 1;
    logic       u_r1, u_r2, u_mv, u_ml, u_err;
    logic [4:0] u_md;
    // Signed instance signals
    logic [3:0] sg_d1 = '0, sg_d2 = '0;
    logic       sg_v1 = 0, sg_v2 = 0, sg_l1 = 0, sg_l2 = 0, sg_mr = 1;
    logic       sg_r1, sg_r2, sg_mv, sg_ml, sg_err;
    logic [4:0] sg_md;

    axis_adder #(.WIDTH(4), .SIGNED_MODE(0)) dut_u (
        .clk_i(clk), .rst_i(rst),
        .s_axis1_tdata_i(u_d1), .s_axis1_tvalid_i(u_v1), .s_axis1_tlast_i(u_l1), .s_axis1_tready_o(u_r1),
        .s_axis2_tdata_i(u_d2), .s_axis2_tvalid_i(u_v2), .s_axis2_tlast_i(u_l2), .s_axis2_tready_o(u_r2),
        .m_axis_tdata_o(u_md), .m_axis_tvalid_o(u_mv), .m_axis_tlast_o(u_ml),
        .m_axis_tready_i(u_mr), .tlast_err_o(u_err)
    );

    axis_adder #(.WIDTH(4), .SIGNED_MODE(1)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .s_axis1_tdata_i(sg_d1), .s_axis1_tvalid_i(sg_v1), .s_axis1_tlast_i(sg_l1), .s_axis1_tready_o(sg_r1),
        .s_axis2_tdata_i(sg_d2), .s_axis2_tvalid_i(sg_v2), .s_axis2_tlast_i(sg_l2), .s_axis2_tready_o(sg_r2),
        .m_axis_tdata_o(sg_md), .m_axis_tvalid_o(sg_mv), .m_axis_tlast_o(sg_ml),
        .m_axis_tready_i(sg_mr), .tlast_err_o(sg_err)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       l1;
        logic       l2;
        logic [4:0] exp_sum;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int u_out  = 0;
    int sg_out = 0;
    logic [5:0] uq[$];
    logic [5:0] sgq[$];

    function automatic logic [4:0] sum_u(input logic [3:0] a, input logic [3:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [4:0] sum_s(input logic [3:0] a, input logic [3:0] b);
        return {a[3], a} + {b[3], b};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on input handshake, pop on output handshake.
    task automatic mon();
        logic [5:0] e;
        if (u_v1 && u_r1 && u_v2 && u_r2) uq.push_back({u_l1, sum_u(u_d1, u_d2)});
        if (u_mv && u_mr) begin
            u_out++;
            if (uq.size() == 0) chk("u_sb_unexpected_beat", 1, 0);
            else begin
                e = uq.pop_front();
                chk("u_sb_data", int'(u_md), int'(e[4:0]));
                chk("u_sb_last", int'(u_ml), int'(e[5]));
                $display("u   beat data=%0d last=%0d", u_md, u_ml);
            end
        end
        if (sg_v1 && sg_r1 && sg_v2 && sg_r2) sgq.push_back({sg_l1, sum_s(sg_d1, sg_d2)});
        if (sg_mv && sg_mr) begin
            sg_out++;
            if (sgq.size() == 0) chk("s_sb_unexpected_beat", 1, 0);
            else begin
                e = sgq.pop_front();
                chk("s_sb_data", int'(sg_md), int'(e[4:0]));
                chk("s_sb_last", int'(sg_ml), int'(e[5]));
                $display("s   beat data=%b last=%0d", sg_md, sg_ml);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic u_drive(input logic [3:0] a, input logic [3:0] b, input logic l1, input logic l2);
        u_d1 = a; u_d2 = b; u_l1 = l1; u_l2 = l2; u_v1 = 1; u_v2 = 1;
    endtask

    task automatic u_idle();
        u_v1 = 0; u_v2 = 0; u_l1 = 0; u_l2 = 0;
    endtask

    vec_t utab[4];
    vec_t stab[4];
    int   base;

    initial begin
        utab[0] = '{4'd4,  4'd1,  1'b0, 1'b0, 5'd5};
        utab[1] = '{4'd9,  4'd3,  1'b0, 1'b0, 5'd12};
        utab[2] = '{4'd13, 4'd13, 1'b1, 1'b1, 5'd26};
        utab[3] = '{4'd5,  4'd2,  1'b0, 1'b0, 5'd7};
        stab[0] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 5'b10000};
        stab[1] = '{4'b0111, 4'b0111, 1'b1, 1'b1, 5'b01110};
        stab[2] = '{4'b1111, 4'b0001, 1'b0, 1'b0, 5'b00000};
        stab[3] = '{4'b1000, 4'b0111, 1'b1, 1'b1, 5'b11111};

        // Reset state, with inputs valid to show nothing is taken.
        u_drive(4'd1, 4'd1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", int'(u_mv), 0);
        chk("rst_tdata", int'(u_md), 0);
        chk("rst_tlast", int'(u_ml), 0);
        chk("rst_err", int'(u_err), 0);
        chk("rst_tready1", int'(u_r1), 0);
        chk("rst_tready2", int'(u_r2), 0);
        u_idle();
        rst = 0;
        tick();

        // Unsigned table, back-to-back, 1-cycle latency.
        for (int i = 0; i < 4; i++) begin
            u_drive(utab[i].a, utab[i].b, utab[i].l1, utab[i].l2);
            tick();
            chk("u_tab_valid", int'(u_mv), 1);
            chk("u_tab_sum", int'(u_md), int'(utab[i].exp_sum));
            chk("u_tab_last", int'(u_ml), int'(utab[i].l1));
        end
        u_idle();
        tick();
        tick();
        chk("u_tab_drained", int'(u_mv), 0);

        // Signed table.
        for (int i = 0; i < 4; i++) begin
            sg_d1 = stab[i].a; sg_d2 = stab[i].b; sg_l1 = stab[i].l1; sg_l2 = stab[i].l2;
            sg_v1 = 1; sg_v2 = 1;
            tick();
            chk("s_tab_valid", int'(sg_mv), 1);
            chk("s_tab_sum", int'(sg_md), int'(stab[i].exp_sum));
        end
        sg_v1 = 0; sg_v2 = 0;
        tick();
        tick();

        // Join skew: stream 1 waits 3 cycles for stream 2.
        base = u_out;
        u_d1 = 4'd3; u_v1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("skew_tready1_low", int'(u_r1), 0);
            chk("skew_tready2_high", int'(u_r2), 1);
            chk("skew_no_output", int'(u_mv), 0);
        end
        u_d2 = 4'd4; u_v2 = 1;
        #1;
        chk("skew_tready1_up", int'(u_r1), 1);
        tick();
        u_idle();
        chk("skew_sum", int'(u_md), 7);
        tick();
        tick();
        chk("skew_one_beat", u_out - base, 1);

        // Backpressure: fill to FULL, hold, drain, resume streaming.
        base = u_out;
        u_mr = 0;
        u_drive(4'd1, 4'd2, 0, 0);
        tick();
        u_drive(4'd3, 4'd4, 0, 0);
        tick();
        u_drive(4'd5, 4'd6, 0, 0);
        #1;
        chk("bp_full_tready1", int'(u_r1), 0);
        chk("bp_full_tready2", int'(u_r2), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", int'(u_md), 3);
            chk("bp_hold_valid", int'(u_mv), 1);
        end
        u_mr = 1;
        tick();
        chk("bp_drain_b", int'(u_md), 7);
        tick();
        chk("bp_drain_c", int'(u_md), 11);
        u_drive(4'd7, 4'd8, 0, 0);
        tick();
        chk("bp_stream_d", int'(u_md), 15);
        chk("bp_stream_ready", int'(u_r1), 1);
        u_drive(4'd2, 4'd2, 1, 1);
        tick();
        chk("bp_stream_e", int'(u_md), 4);
        u_idle();
        tick();
        tick();
        chk("bp_beat_count", u_out - base, 5);

        // tlast mismatch sets a sticky error.
        chk("tl_err_clear", int'(u_err), 0);
        u_drive(4'd1, 4'd1, 1, 0);
        tick();
        chk("tl_out_last", int'(u_ml), 1);
        chk("tl_err_set", int'(u_err), 1);
        u_drive(4'd2, 4'd3, 0, 0);
        tick();
        chk("tl_err_held", int'(u_err), 1);
        chk("tl_matched_last", int'(u_ml), 0);
        u_idle();
        tick();
        tick();
        chk("tl_err_sticky", int'(u_err), 1);

        // Reset while FULL discards buffered beats asynchronously.
        u_mr = 0;
        u_drive(4'd10, 4'd1, 0, 0);
        tick();
        u_drive(4'd11, 4'd1, 0, 0);
        tick();
        u_idle();
        #2;
        rst = 1;
        #1;
        chk("arst_tvalid", int'(u_mv), 0);
        chk("arst_tdata", int'(u_md), 0);
        chk("arst_err", int'(u_err), 0);
        uq.delete();
        sgq.delete();
        u_drive(4'd6, 4'd9, 0, 0);
        #1;
        chk("arst_tready1", int'(u_r1), 0);
        tick();
        chk("arst_hold_tvalid", int'(u_mv), 0);
        rst = 0;
        u_mr = 1;
        tick();
        chk("arst_new_valid", int'(u_mv), 1);
        chk("arst_new_sum", int'(u_md), 15);
        u_idle();
        tick();
        chk("arst_no_stale", int'(u_mv), 0);
        tick();

        chk("u_sb_empty", uq.size(), 0);
        chk("s_sb_empty", sgq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_axis_adder
